// File: rtl/cpu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared constants for the 16-bit processor's multi-cycle control unit:
//   - opcode encodings (OP_RTYPE .. OP_JMP)
//   - R-type function codes (FN_ADD .. FN_AND)
//   - ALU operation codes driven on ALUop
//   - FSM state encoding (FETCH, DECODE, EXEC, MEM, WB, BRANCH, JUMP, TRAP)
//   - instruction class produced by ctrl_decode
// ---------------------------------------------------------------------------
package cpu_ctrl_pkg;

  // Opcodes; 0111-1111 are undefined
  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_LW    = 4'b0001;
  localparam logic [3:0] OP_SW    = 4'b0010;
  localparam logic [3:0] OP_ADDI  = 4'b0011;
  localparam logic [3:0] OP_BEQ   = 4'b0100;
  localparam logic [3:0] OP_BNE   = 4'b0101;
  localparam logic [3:0] OP_JMP   = 4'b0110;

  // R-type function codes; 0100-1111 are undefined
  localparam logic [3:0] FN_ADD = 4'b0000;
  localparam logic [3:0] FN_SUB = 4'b0001;
  localparam logic [3:0] FN_SLL = 4'b0010;
  localparam logic [3:0] FN_AND = 4'b0011;

  // ALU operations used directly by the FSM (R-type passes funct through)
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  // FSM state encoding, kept as plain constants for legacy tools
  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;
  localparam logic [2:0] BRANCH = 3'd5;
  localparam logic [2:0] JUMP   = 3'd6;
  localparam logic [2:0] TRAP   = 3'd7;

  typedef enum logic [2:0] {
    CLS_RTYPE  = 3'd0,
    CLS_LW     = 3'd1,
    CLS_SW     = 3'd2,
    CLS_ADDI   = 3'd3,
    CLS_BRANCH = 3'd4,
    CLS_JUMP   = 3'd5,
    CLS_NONE   = 3'd6
  } instr_class_t;

  function automatic logic funct_is_legal(input logic [3:0] funct);
    logic ok;
    case (funct)
      FN_ADD, FN_SUB, FN_SLL, FN_AND: ok = 1'b1;
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ---------------------------------------------------------------------------
// ctrl_decode
// Combinational classifier for a latched opcode/function pair.
// Ports:
//   opcode         in   OPC_W    latched opcode
//   function_code  in   FUNCT_W  latched R-type function field
//   instr_class    out  class    instruction class (CLS_NONE when undefined)
//   legal          out  1        1 when the encoding is defined
// ---------------------------------------------------------------------------
module ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int OPC_W   = 4,
  parameter int FUNCT_W = 4
) (
  input  logic [OPC_W-1:0]   opcode,
  input  logic [FUNCT_W-1:0] function_code,
  output instr_class_t       instr_class,
  output logic               legal
);

  always_comb begin
    instr_class = CLS_NONE;
    legal       = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        // An R-type with an unknown funct is as undefined as a bad opcode
        if (funct_is_legal(function_code)) begin
          instr_class = CLS_RTYPE;
          legal       = 1'b1;
        end
      end
      OP_LW: begin
        instr_class = CLS_LW;
        legal       = 1'b1;
      end
      OP_SW: begin
        instr_class = CLS_SW;
        legal       = 1'b1;
      end
      OP_ADDI: begin
        instr_class = CLS_ADDI;
        legal       = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        instr_class = CLS_BRANCH;
        legal       = 1'b1;
      end
      OP_JMP: begin
        instr_class = CLS_JUMP;
        legal       = 1'b1;
      end
      default: begin
        instr_class = CLS_NONE;
        legal       = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit
// FSM that sequences FETCH/DECODE/EXEC/MEM/WB (plus BRANCH, JUMP and TRAP)
// for the 16-bit processor and drives the per-state datapath enables.
//
// Configuration macro: ILLEGAL_TRAP_EN
//   defined   - undefined encodings park the FSM in TRAP with illegal=1
//               until rst_n is asserted.
//   undefined - undefined encodings retire as a NOP from DECODE and
//               illegal is constant 0.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   instr_valid      fetch data valid (consumed in FETCH)
//   opcode           opcode, latched on FETCH accept
//   function_code    R-type funct, latched with opcode
//   mem_ready        data memory done (consumed in MEM)
//   pc_write         PC update strobe (FETCH accept, JUMP)
//   ir_write         instruction register load (FETCH accept)
//   RegDst           1 = rd destination, 0 = rt
//   RegWrite         register-file write enable (WB)
//   Branch           branch compare cycle
//   Jump             jump PC select
//   ALUop            ALU operation
//   MemRead          data-memory read request (lw in MEM)
//   MemWrite         data-memory write request (sw in MEM)
//   RegWriteSource   1 = memory data, 0 = ALU result
//   ALUSource        1 = immediate, 0 = register
//   busy             high except while idling in FETCH
//   instr_done       1-cycle pulse in the last state of an instruction
//   illegal          undefined encoding trapped
// ---------------------------------------------------------------------------
module multicycle_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int OPC_W   = 4,
  parameter int FUNCT_W = 4,
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  input  logic [OPC_W-1:0]   opcode,
  input  logic [FUNCT_W-1:0] function_code,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               Branch,
  output logic               Jump,
  output logic [ALUOP_W-1:0] ALUop,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               RegWriteSource,
  output logic               ALUSource,
  output logic               busy,
  output logic               instr_done,
  output logic               illegal
);

  logic [2:0]         state;
  logic [2:0]         state_next;
  logic [OPC_W-1:0]   opcode_q;
  logic [FUNCT_W-1:0] funct_q;
  instr_class_t       instr_class;
  logic               legal;

  ctrl_decode #(
    .OPC_W   (OPC_W),
    .FUNCT_W (FUNCT_W)
  ) u_decode (
    .opcode        (opcode_q),
    .function_code (funct_q),
    .instr_class   (instr_class),
    .legal         (legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      opcode_q <= '0;
      funct_q  <= '0;
    end else begin
      state <= state_next;
      if (state == FETCH && instr_valid) begin
        opcode_q <= opcode;
        funct_q  <= function_code;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH: begin
        if (instr_valid) state_next = DECODE;
      end
      DECODE: begin
        if (!legal) begin
`ifdef ILLEGAL_TRAP_EN
          state_next = TRAP;
`else
          state_next = FETCH;
`endif
        end else begin
          case (instr_class)
            CLS_BRANCH: state_next = BRANCH;
            CLS_JUMP:   state_next = JUMP;
            default:    state_next = EXEC;
          endcase
        end
      end
      EXEC: begin
        if (instr_class == CLS_LW || instr_class == CLS_SW) state_next = MEM;
        else                                                state_next = WB;
      end
      MEM: begin
        if (mem_ready) begin
          if (instr_class == CLS_LW) state_next = WB;
          else                       state_next = FETCH;
        end
      end
      WB, BRANCH, JUMP: state_next = FETCH;
      TRAP: begin
`ifdef ILLEGAL_TRAP_EN
        state_next = TRAP;
`else
        state_next = FETCH;
`endif
      end
      default: state_next = FETCH;
    endcase
  end

  // FETCH strobes depend on instr_valid directly, so they are gated with
  // rst_n to keep every output low while reset is held.
  always_comb begin
    pc_write       = 1'b0;
    ir_write       = 1'b0;
    RegDst         = 1'b0;
    RegWrite       = 1'b0;
    Branch         = 1'b0;
    Jump           = 1'b0;
    ALUop          = '0;
    MemRead        = 1'b0;
    MemWrite       = 1'b0;
    RegWriteSource = 1'b0;
    ALUSource      = 1'b0;
    busy           = 1'b0;
    instr_done     = 1'b0;
    illegal        = 1'b0;
    case (state)
      FETCH: begin
        if (instr_valid && rst_n) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          busy     = 1'b1;
        end
      end
      DECODE: begin
        busy = 1'b1;
`ifndef ILLEGAL_TRAP_EN
        if (!legal) instr_done = 1'b1;
`endif
      end
      EXEC: begin
        busy = 1'b1;
        if (instr_class == CLS_RTYPE) begin
          ALUop = ALUOP_W'(funct_q);
        end else begin
          ALUop     = ALUOP_W'(ALU_ADD);
          ALUSource = 1'b1;
        end
      end
      MEM: begin
        // sw retires in the cycle memory reports done
        busy = 1'b1;
        if (instr_class == CLS_LW) begin
          MemRead = 1'b1;
        end else begin
          MemWrite   = 1'b1;
          instr_done = mem_ready;
        end
      end
      WB: begin
        busy           = 1'b1;
        RegWrite       = 1'b1;
        instr_done     = 1'b1;
        RegDst         = (instr_class == CLS_RTYPE);
        RegWriteSource = (instr_class == CLS_LW);
      end
      BRANCH: begin
        busy       = 1'b1;
        ALUop      = ALUOP_W'(ALU_SUB);
        Branch     = 1'b1;
        instr_done = 1'b1;
      end
      JUMP: begin
        busy       = 1'b1;
        Jump       = 1'b1;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      TRAP: begin
`ifdef ILLEGAL_TRAP_EN
        busy    = 1'b1;
        illegal = 1'b1;
`endif
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_unit
// Self-checking bench for multicycle_control_unit. Each instruction is
// expanded from its class into a per-cycle list of inputs and expected
// outputs; a compare process checks the DUT on every cycle of that list.
// Honours ILLEGAL_TRAP_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic [3:0] opcode = '0;
  logic [3:0] function_code = '0;
  logic       mem_ready = 1'b0;

  logic       pc_write, ir_write, RegDst, RegWrite, Branch, Jump;
  logic [3:0] ALUop;
  logic       MemRead, MemWrite, RegWriteSource, ALUSource;
  logic       busy, instr_done, illegal;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       reg_dst;
    logic       reg_write;
    logic       branch;
    logic       jump;
    logic [3:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write_source;
    logic       alu_source;
    logic       busy;
    logic       instr_done;
    logic       illegal;
  } outs_t;

  typedef struct {
    string      label;
    logic       iv;
    logic [3:0] op;
    logic [3:0] fn;
    logic       mr;
    outs_t      exp;
  } step_t;

  outs_t dut_outs;
  assign dut_outs = {pc_write, ir_write, RegDst, RegWrite, Branch, Jump, ALUop,
                     MemRead, MemWrite, RegWriteSource, ALUSource, busy,
                     instr_done, illegal};

  step_t plan[$];
  step_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Per-instruction observations, restarted on every ir_write
  int cyc = 0;
  int off = 0;
  int done_off = -1;
  int ill_off = -1;
  int mr_cnt = 0;
  int mw_cnt = 0;
  int rw_cnt = 0;
  int br_cyc = -1;
  int jmp_cyc = -1;

  multicycle_control_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instr_valid    (instr_valid),
    .opcode         (opcode),
    .function_code  (function_code),
    .mem_ready      (mem_ready),
    .pc_write       (pc_write),
    .ir_write       (ir_write),
    .RegDst         (RegDst),
    .RegWrite       (RegWrite),
    .Branch         (Branch),
    .Jump           (Jump),
    .ALUop          (ALUop),
    .MemRead        (MemRead),
    .MemWrite       (MemWrite),
    .RegWriteSource (RegWriteSource),
    .ALUSource      (ALUSource),
    .busy           (busy),
    .instr_done     (instr_done),
    .illegal        (illegal)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input outs_t actual, input outs_t expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic check_value(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic add_step(input string label, input logic iv, input logic [3:0] op,
                          input logic [3:0] fn, input logic mr, input outs_t e);
    step_t s;
    s.label = label;
    s.iv    = iv;
    s.op    = op;
    s.fn    = fn;
    s.mr    = mr;
    s.exp   = e;
    plan.push_back(s);
  endtask

  // Non-FETCH cycles carry random garbage on every input the state ignores
  task automatic add_busy_step(input string label, input outs_t e, input logic mr);
    add_step(label, 1'($urandom), 4'($urandom), 4'($urandom), mr, e);
  endtask

  // Expand one instruction into its cycle-by-cycle behaviour
  task automatic plan_instr(input int idle, input logic [3:0] op, input logic [3:0] fn,
                            input int waits);
    outs_t e;
    logic  legal;
    for (int i = 0; i < idle; i++) begin
      e = '0;
      add_step("idle", 1'b0, 4'($urandom), 4'($urandom), 1'($urandom), e);
    end
    e = '0;
    e.ir_write = 1'b1;
    e.pc_write = 1'b1;
    e.busy     = 1'b1;
    add_step("accept", 1'b1, op, fn, 1'($urandom), e);

    legal = (op <= 4'd6) && !(op == 4'd0 && fn > 4'd3);
    e = '0;
    e.busy = 1'b1;
    if (!legal) begin
`ifdef ILLEGAL_TRAP_EN
      add_busy_step("decode_illegal", e, 1'($urandom));
      e.illegal = 1'b1;
      for (int i = 0; i < 5; i++) add_busy_step("trap", e, 1'($urandom));
`else
      e.instr_done = 1'b1;
      add_busy_step("decode_nop", e, 1'($urandom));
`endif
      return;
    end
    add_busy_step("decode", e, 1'($urandom));

    case (op)
      4'd0: begin
        e = '0; e.busy = 1'b1; e.alu_op = fn;
        add_busy_step("exec_r", e, 1'($urandom));
        e = '0; e.busy = 1'b1; e.reg_write = 1'b1; e.reg_dst = 1'b1; e.instr_done = 1'b1;
        add_busy_step("wb_r", e, 1'($urandom));
      end
      4'd1, 4'd2, 4'd3: begin
        e = '0; e.busy = 1'b1; e.alu_source = 1'b1; e.alu_op = 4'd0;
        add_busy_step("exec_imm", e, 1'($urandom));
        if (op != 4'd3) begin
          for (int j = 0; j <= waits; j++) begin
            e = '0; e.busy = 1'b1;
            e.mem_read   = (op == 4'd1);
            e.mem_write  = (op == 4'd2);
            e.instr_done = (op == 4'd2) && (j == waits);
            add_busy_step("mem", e, j == waits);
          end
        end
        if (op != 4'd2) begin
          e = '0; e.busy = 1'b1; e.reg_write = 1'b1; e.instr_done = 1'b1;
          e.reg_write_source = (op == 4'd1);
          add_busy_step("wb_imm", e, 1'($urandom));
        end
      end
      4'd4, 4'd5: begin
        e = '0; e.busy = 1'b1; e.alu_op = 4'd1; e.branch = 1'b1; e.instr_done = 1'b1;
        add_busy_step("branch", e, 1'($urandom));
      end
      default: begin
        e = '0; e.busy = 1'b1; e.jump = 1'b1; e.pc_write = 1'b1; e.instr_done = 1'b1;
        add_busy_step("jump", e, 1'($urandom));
      end
    endcase
  endtask

  // Drive each planned cycle just after the rising edge; ends just after
  // the falling edge of the last planned cycle, once it has been compared
  task automatic apply_stimulus();
    step_t s;
    while (plan.size() > 0) begin
      s = plan.pop_front();
      @(posedge clk);
      #1;
      instr_valid   = s.iv;
      opcode        = s.op;
      function_code = s.fn;
      mem_ready     = s.mr;
      exp_q.push_back(s);
    end
    @(negedge clk);
    #1;
  endtask

  // Called just after a falling edge: asserts reset before the next rising
  // edge, so the instruction in flight is abandoned in its current state
  task automatic reset_now(input string name);
    #2;
    rst_n       = 1'b0;
    instr_valid = 1'b1;
    #1;
    check_output(name, dut_outs, '0);
    instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_output({name, "_release_idle"}, dut_outs, '0);
  endtask

  initial begin : compare_proc
    step_t s;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        s = exp_q.pop_front();
        check_output(s.label, dut_outs, s.exp);
      end
      cyc++;
      if (ir_write) begin
        off = 0; done_off = -1; ill_off = -1; mr_cnt = 0; mw_cnt = 0; rw_cnt = 0;
      end else begin
        off++;
      end
      if (MemRead) mr_cnt++;
      if (MemWrite) mw_cnt++;
      if (RegWrite) rw_cnt++;
      if (Branch) br_cyc = cyc;
      if (Jump) jmp_cyc = cyc;
      if (instr_done) done_off = off;
      if (illegal && ill_off < 0) ill_off = off;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] time limit expired");
  end

  initial begin : main_proc
    logic [3:0] op;
    logic [3:0] fn;

    // Reset state, including with instr_valid high while reset is held
    #2;
    check_output("reset_state", dut_outs, '0);
    instr_valid = 1'b1;
    #1;
    check_output("reset_ignores_valid", dut_outs, '0);
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_output("post_reset_idle", dut_outs, '0);

    // add
    plan_instr(1, 4'd0, 4'd0, 0);
    apply_stimulus();
    check_value("add_done_cycle", done_off, 3);
    check_value("add_regwrite_cycles", rw_cnt, 1);

    // lw with three not-ready cycles
    plan_instr(0, 4'd1, 4'd7, 3);
    apply_stimulus();
    check_value("lw_done_cycle", done_off, 7);
    check_value("lw_memread_cycles", mr_cnt, 4);

    // sw with mem_ready already high
    plan_instr(0, 4'd2, 4'd0, 0);
    apply_stimulus();
    check_value("sw_done_cycle", done_off, 3);
    check_value("sw_memwrite_cycles", mw_cnt, 1);
    check_value("sw_regwrite_cycles", rw_cnt, 0);

    // beq then jmp back-to-back
    plan_instr(2, 4'd4, 4'd9, 0);
    plan_instr(0, 4'd6, 4'd3, 0);
    apply_stimulus();
    check_value("jmp_done_cycle", done_off, 2);
    check_value("beq_to_jump_distance", jmp_cyc - br_cyc, 3);

    // Reset in the middle of an add's EXEC
    plan_instr(0, 4'd0, 4'd1, 0);
    void'(plan.pop_back());
    apply_stimulus();
    reset_now("reset_mid_exec");
    plan_instr(2, 4'd5, 4'd0, 0);
    apply_stimulus();

    // Reset while lw waits in MEM: MemRead must drop at once
    plan_instr(0, 4'd1, 4'd0, 5);
    repeat (5) void'(plan.pop_back());
    apply_stimulus();
    reset_now("reset_mid_mem");

    // Randomized instruction stream
    for (int n = 0; n < 150; n++) begin
      op = 4'($urandom_range(0, 6));
      fn = 4'($urandom_range(0, 3));
`ifndef ILLEGAL_TRAP_EN
      if ($urandom_range(0, 9) == 0) op = 4'($urandom_range(7, 15));
      if (op == 4'd0 && $urandom_range(0, 9) == 0) fn = 4'($urandom_range(4, 15));
`endif
      plan_instr($urandom_range(0, 2), op, fn, $urandom_range(0, 3));
    end
    apply_stimulus();

    // Undefined opcode 1010
    plan_instr(1, 4'hA, 4'd0, 0);
    apply_stimulus();
`ifdef ILLEGAL_TRAP_EN
    check_value("illegal_first_cycle", ill_off, 2);
    check_value("illegal_no_done", done_off, -1);
    reset_now("reset_from_trap");
`else
    check_value("nop_done_cycle", done_off, 1);
    check_value("nop_write_strobes", rw_cnt + mw_cnt + mr_cnt, 0);
    // R-type with undefined funct behaves the same
    plan_instr(0, 4'd0, 4'd9, 0);
    apply_stimulus();
    check_value("bad_funct_done_cycle", done_off, 1);
`endif

    // Normal operation after the last reset
    plan_instr(1, 4'd3, 4'd0, 0);
    apply_stimulus();
    check_value("addi_done_cycle", done_off, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
